// File: rtl/gray_to_binary_conv_16_bit_if.sv
// Data/enable bundle for the Gray-to-binary converter; the master drives Gray words, the slave returns binary.
interface gray_to_binary_conv_16_bit_if #(
  parameter int unsigned WIDTH = 16
);
  logic             Enable_In;
  logic [WIDTH-1:0] Gray_Data_In;
  logic [WIDTH-1:0] Binary_Data_Out;
  logic             Valid_Out;

  modport master (
    output Enable_In,
    output Gray_Data_In,
    input  Binary_Data_Out,
    input  Valid_Out
  );

  modport slave (
    input  Enable_In,
    input  Gray_Data_In,
    output Binary_Data_Out,
    output Valid_Out
  );
endinterface

// File: rtl/gray_to_binary_conv_16_bit.sv
// Registered Gray-to-binary converter with tri-stated output when disabled.
// Define GRAY_TO_BINARY_PIPE_EN for a two-stage (latency 2) split of the prefix XOR.
module gray_to_binary_conv_16_bit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                          Clk_In,
  input  logic                          Reset_n_In,
  gray_to_binary_conv_16_bit_if.slave   bus
);

  logic [WIDTH-1:0] bin;
  logic             en_out;

`ifdef GRAY_TO_BINARY_PIPE_EN
  localparam int unsigned HALF = WIDTH / 2;

  logic             en_s1_q, en_s2_q;
  logic [WIDTH-1:0] gray_s1_q;
  logic [WIDTH-1:0] s2_d, s2_q;

  always_ff @(posedge Clk_In) begin
    if (!Reset_n_In) begin
      en_s1_q   <= 1'b0;
      en_s2_q   <= 1'b0;
      gray_s1_q <= '0;
      s2_q      <= '0;
    end else begin
      en_s1_q   <= bus.Enable_In;
      en_s2_q   <= en_s1_q;
      gray_s1_q <= bus.Gray_Data_In;
      s2_q      <= s2_d;
    end
  end

  // Stage 1 resolves the upper half; the lower half still carries raw Gray bits.
  always_comb begin
    s2_d = gray_s1_q;
    for (int unsigned i = WIDTH - 1; i > HALF; i--) begin
      s2_d[i-1] = gray_s1_q[i-1] ^ s2_d[i];
    end
  end

  always_comb begin
    bin = s2_q;
    for (int unsigned i = HALF; i > 0; i--) begin
      bin[i-1] = s2_q[i-1] ^ bin[i];
    end
  end

  assign en_out = en_s2_q;
`else
  logic             en_q;
  logic [WIDTH-1:0] gray_q;

  always_ff @(posedge Clk_In) begin
    if (!Reset_n_In) begin
      en_q   <= 1'b0;
      gray_q <= '0;
    end else begin
      en_q   <= bus.Enable_In;
      gray_q <= bus.Gray_Data_In;
    end
  end

  always_comb begin
    bin = gray_q;
    for (int unsigned i = WIDTH - 1; i > 0; i--) begin
      bin[i-1] = gray_q[i-1] ^ bin[i];
    end
  end

  assign en_out = en_q;
`endif

  assign bus.Binary_Data_Out = en_out ? bin : 'z;
  assign bus.Valid_Out       = en_out;

endmodule

// File: tb/tb_gray_to_binary_conv_16_bit.sv
// Directed plus random bench for the Gray-to-binary converter using an expected-output queue.
module tb_gray_to_binary_conv_16_bit;
  localparam int unsigned WIDTH = 16;
`ifdef GRAY_TO_BINARY_PIPE_EN
  localparam int unsigned LAT = 2;
`else
  localparam int unsigned LAT = 1;
`endif

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  logic [WIDTH:0] exp_q[$];

  gray_to_binary_conv_16_bit_if #(.WIDTH(WIDTH)) bus ();

  gray_to_binary_conv_16_bit #(.WIDTH(WIDTH)) dut (
    .Clk_In     (clk),
    .Reset_n_In (rst_n),
    .bus        (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit i of the binary word is the parity of every Gray bit at or above i.
  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = ^(g >> i);
    end
    return r;
  endfunction

  task automatic check_out(input string tag);
    logic [WIDTH:0]   e;
    logic             ev;
    logic [WIDTH-1:0] ed;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s: scoreboard empty, got valid=%b data=%h", tag, bus.Valid_Out, bus.Binary_Data_Out);
      return;
    end
    e  = exp_q.pop_front();
    ev = e[WIDTH];
    ed = e[WIDTH-1:0];
    tests++;
    assert (bus.Valid_Out === ev) else begin
      fails++;
      $error("FAIL %s valid: got %b expected %b", tag, bus.Valid_Out, ev);
    end
    tests++;
    assert (bus.Binary_Data_Out === ed) else begin
      fails++;
      $error("FAIL %s data: got %h expected %h", tag, bus.Binary_Data_Out, ed);
    end
  endtask

  // One clock: drive inputs, record what must appear LAT edges later, compare the oldest entry.
  task automatic step(input string tag, input logic rn, input logic en,
                      input logic [WIDTH-1:0] g, input logic [WIDTH-1:0] exp_b);
    logic [WIDTH-1:0] zz;
    zz = 'z;
    rst_n            = rn;
    bus.Enable_In    = en;
    bus.Gray_Data_In = g;
    @(posedge clk);
    if (!rn) begin
      exp_q.delete();
      for (int i = 0; i < int'(LAT); i++) exp_q.push_back({1'b0, zz});
    end else if (en) begin
      exp_q.push_back({1'b1, exp_b});
    end else begin
      exp_q.push_back({1'b0, zz});
    end
    #1;
    if (exp_q.size() >= LAT) check_out(tag);
  endtask

  initial begin
    logic             ren;
    logic [WIDTH-1:0] rg;
    tests = 0;
    fails = 0;
    rst_n            = 1'b0;
    bus.Enable_In    = 1'b1;
    bus.Gray_Data_In = 16'hFFFF;

    step("reset0", 1'b0, 1'b1, 16'hFFFF, 16'h0000);
    step("reset1", 1'b0, 1'b1, 16'hFFFF, 16'h0000);

    step("walk0001", 1'b1, 1'b1, 16'h0001, 16'h0001);
    step("walk0002", 1'b1, 1'b1, 16'h0002, 16'h0003);
    step("walk0004", 1'b1, 1'b1, 16'h0004, 16'h0007);
    step("walk4000", 1'b1, 1'b1, 16'h4000, 16'h7FFF);
    step("walk8000", 1'b1, 1'b1, 16'h8000, 16'hFFFF);

    step("mixC000", 1'b1, 1'b1, 16'hC000, 16'h8000);
    step("mix0000", 1'b1, 1'b1, 16'h0000, 16'h0000);
    step("mixFFFF", 1'b1, 1'b1, 16'hFFFF, 16'hAAAA);

    step("disable", 1'b1, 1'b0, 16'h1234, 16'h0000);
    step("reenable", 1'b1, 1'b1, 16'h0003, 16'h0002);

    step("mid0001", 1'b1, 1'b1, 16'h0001, 16'h0001);
    step("midrst", 1'b0, 1'b1, 16'h0002, 16'h0003);
    step("mid0004", 1'b1, 1'b1, 16'h0004, 16'h0007);
    step("mid0010", 1'b1, 1'b1, 16'h0010, 16'h001F);

    for (int k = 0; k < 20; k++) begin
      ren = 1'($urandom_range(0, 1));
      rg  = WIDTH'($urandom);
      step("random", 1'b1, ren, rg, model(rg));
    end

    step("drain", 1'b1, 1'b0, 16'h0000, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/gray_to_binary_conv_16_bit.md
Name: gray_to_binary_conv_16_bit

Overview:
- Registered Gray-code to binary converter, 16 bits by default; width is parameterised.
- Sits on the data path after Gray-coded sources, such as async-FIFO pointers or rotary encoders.
- Has an enable. When the captured enable is low, the data output floats (high-Z) so several converters can share one bus.

Parameters:
- WIDTH, 16, data width in bits; legal range 2..64.

Ports:
- Clk_In  input  1  rising-edge clock.
- Reset_n_In  input  1  synchronous reset, active low.
- Enable_In  input  1  conversion enable, sampled on each clock edge.
- Gray_Data_In  input  WIDTH  Gray-coded input word.
- Binary_Data_Out  output  WIDTH  converted binary word; high-Z when not enabled.
- Valid_Out  output  1  high when Binary_Data_Out carries a converted word.

Behaviour:
- All state updates on the rising edge of Clk_In; there are no asynchronous paths.
- Reset: Reset_n_In low at a clock edge clears the following on that edge:
  - the enable register (to 0), which makes Valid_Out 0 and Binary_Data_Out high-Z;
  - the data register (to all zeros).
- Reset has priority over all other inputs.
- Capture: each non-reset edge registers Enable_In and Gray_Data_In unconditionally.
- Conversion on the registered Gray word g:
  - b[WIDTH-1] = g[WIDTH-1];
  - b[i] = g[i] XOR b[i+1] for i = WIDTH-2 down to 0, i.e. b[i] is the XOR of g[WIDTH-1:i].
  - Pure prefix-XOR; no carries, no overflow, every input code is legal.
- Output:
  - Binary_Data_Out = b when the registered enable = 1, otherwise all bits 'z'.
  - Valid_Out = registered enable.
  - Latency is 1 cycle: inputs present at edge N appear after edge N.
- Throughput: one word per cycle; no back-pressure and no handshake beyond Valid_Out.
- Enable toggling:
  - Enable low for one cycle gives exactly one cycle of high-Z and Valid_Out = 0.
  - Data sampled while enable is low is discarded, not held.
- Reset mid-stream: the word in flight is dropped; the first valid output appears one cycle after the first enabled, non-reset edge.
- Unknown inputs: X on Gray_Data_In propagates to the affected output bits; no X-masking is required.

Optional Feature:
- Macro GRAY_TO_BINARY_PIPE_EN.
- Defined: two-stage pipeline, latency 2 cycles.
  - Stage 1 registers the Gray word and computes the upper-half prefix XOR b[WIDTH-1:WIDTH/2].
  - Stage 2 registers the stage-1 result, completes the lower half, and registers the enable alongside.
  - Valid_Out and the high-Z gating follow the stage-2 enable.
  - Reset clears both stages.
- Undefined: single-stage, latency 1, as above.
- In both modes the conversion result is identical.

Test Plan:
- Reset: hold Reset_n_In = 0 for 2 cycles with Enable_In = 1 and Gray = 0xFFFF -> Valid_Out = 0 and Binary_Data_Out = 16'hzzzz throughout reset.
- Walking ones, Enable_In = 1 (one-hot Gray input fills all lower bits):
  - Gray 0x0001 -> 0x0001
  - Gray 0x0002 -> 0x0003
  - Gray 0x0004 -> 0x0007
  - Gray 0x4000 -> 0x7FFF
  - Gray 0x8000 -> 0xFFFF
  - Each appears 1 cycle later (2 with GRAY_TO_BINARY_PIPE_EN), with Valid_Out = 1.
- Mixed codes:
  - Gray 0xC000 -> 0x8000
  - Gray 0x0000 -> 0x0000
  - Gray 0xFFFF -> 0xAAAA
- Disable: Enable_In = 0 with Gray = 0x1234 -> Binary_Data_Out = 16'hzzzz and Valid_Out = 0 for exactly the matching output cycle. Re-enabling with Gray 0x0003 -> 0x0002.
- Reset mid-stream: stream Gray 0x0001, 0x0002, 0x0004 with reset asserted on the second edge -> the outputs for the in-flight words are dropped. Output is high-Z until one cycle after the next enabled edge.
- Random: 20 random {Enable_In, Gray} pairs, each checked with === against the prefix-XOR model (expected high-Z when Enable_In = 0) -> 0 failures.
